// File: rtl/pin_state_filter_pkg.sv
// Shared lane-sensor constants: channel count, pin level encoding and 100 MHz timing defaults.
package pin_state_filter_pkg;

    localparam int unsigned N_PINS = 3;

    // Filtered pin level encoding used by every consumer of pin_state
    localparam logic PIN_UP   = 1'b1;
    localparam logic PIN_DOWN = 1'b0;

    // 10 ms stability window and 1 s settle time at 100 MHz
    localparam int unsigned STABLE_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned SETTLE_CYCLES_DEFAULT = 100_000_000;

endpackage

// File: rtl/pin_state_filter_channel.sv
// One IR pin channel: two-flop synchroniser, stability filter and edge pulses.
module pin_channel_filter #(
    parameter int unsigned STABLE_CYCLES = pin_state_filter_pkg::STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic ir_n_i,
    output logic state_o,
    output logic fall_o,
    output logic rise_o,
    output logic state_d_c_o,
    output logic flip_c_o
);
    import pin_state_filter_pkg::*;

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             sample_c;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             state_q;
    logic             state_d;
    logic             fall_q;
    logic             fall_d;
    logic             rise_q;
    logic             rise_d;

    // Bring the asynchronous sensor line into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ir_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Active-low sensor: reflected beam (0) means the pin is standing
    assign sample_c = ~sync2_q;

    // Count consecutive disagreeing samples; any agreeing sample discards progress
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        fall_d  = 1'b0;
        rise_d  = 1'b0;
        if (sample_c == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = sample_c;
            fall_d  = (sample_c == PIN_DOWN);
            rise_d  = (sample_c == PIN_UP);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Filter state, counter and one-cycle edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= PIN_UP;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            fall_q  <= fall_d;
            rise_q  <= rise_d;
        end
    end

    assign state_o     = state_q;
    assign fall_o      = fall_q;
    assign rise_o      = rise_q;
    assign state_d_c_o = state_d;
    assign flip_c_o    = (state_d != state_q);

endmodule

// File: rtl/pin_state_filter.sv
// Lane pin conditioner: per-pin filtering plus down count and lane-settled detection.
module pin_state_filter #(
    parameter int unsigned N_PINS        = pin_state_filter_pkg::N_PINS,
    parameter int unsigned STABLE_CYCLES = pin_state_filter_pkg::STABLE_CYCLES_DEFAULT,
    parameter int unsigned SETTLE_CYCLES = pin_state_filter_pkg::SETTLE_CYCLES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PINS-1:0]             ir_n_i,
    input  logic                          arm_i,
    output logic [N_PINS-1:0]             pin_state_o,
    output logic [N_PINS-1:0]             pin_down_o,
    output logic [N_PINS-1:0]             pin_up_o,
    output logic [$clog2(N_PINS+1)-1:0]   down_count_o,
    output logic                          all_down_o,
    output logic                          settled_o,
    output logic                          settle_pulse_o
);
    import pin_state_filter_pkg::*;

    localparam int unsigned DC_W  = $clog2(N_PINS + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_CYCLES);

    logic [N_PINS-1:0] state_c;
    logic [N_PINS-1:0] fall_c;
    logic [N_PINS-1:0] rise_c;
    logic [N_PINS-1:0] state_d_c;
    logic [N_PINS-1:0] flip_c;

    logic [DC_W-1:0]   down_count_q;
    logic [DC_W-1:0]   down_count_d;
    logic              all_down_q;
    logic              all_down_d;

    logic              clear_c;
    logic [SET_W-1:0]  settle_cnt_q;
    logic [SET_W-1:0]  settle_cnt_d;
    logic              settled_q;
    logic              settled_d;
    logic              settle_pulse_q;
    logic              settle_pulse_d;

    // One independent filter per sensor channel
    for (genvar g = 0; g < int'(N_PINS); g++) begin : g_chan
        pin_channel_filter #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .ir_n_i      (ir_n_i[g]),
            .state_o     (state_c[g]),
            .fall_o      (fall_c[g]),
            .rise_o      (rise_c[g]),
            .state_d_c_o (state_d_c[g]),
            .flip_c_o    (flip_c[g])
        );
    end

    // Summaries come from the next pin state so they move on the same edge as pin_state
    always_comb begin
        down_count_d = '0;
        for (int unsigned i = 0; i < N_PINS; i++) begin
            if (state_d_c[i] == PIN_DOWN) begin
                down_count_d = down_count_d + DC_W'(1);
            end
        end
        all_down_d = (state_d_c == '0);
    end

    // Settle timer: restart on any filtered flip or arm, otherwise count up and hold at the limit
    always_comb begin
        clear_c      = (|flip_c) | arm_i;
        settle_cnt_d = settle_cnt_q;
        if (clear_c) begin
            settle_cnt_d = '0;
        end else if (settle_cnt_q != SETTLE_MAX) begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
        settled_d      = (settle_cnt_d == SETTLE_MAX);
        settle_pulse_d = settled_d & ~settled_q;
    end

    // Registered summary and settle outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_count_q   <= '0;
            all_down_q     <= 1'b0;
            settle_cnt_q   <= '0;
            settled_q      <= 1'b0;
            settle_pulse_q <= 1'b0;
        end else begin
            down_count_q   <= down_count_d;
            all_down_q     <= all_down_d;
            settle_cnt_q   <= settle_cnt_d;
            settled_q      <= settled_d;
            settle_pulse_q <= settle_pulse_d;
        end
    end

    assign pin_state_o    = state_c;
    assign pin_down_o     = fall_c;
    assign pin_up_o       = rise_c;
    assign down_count_o   = down_count_q;
    assign all_down_o     = all_down_q;
    assign settled_o      = settled_q;
    assign settle_pulse_o = settle_pulse_q;

endmodule

// File: tb/tb_pin_state_filter.sv
// Self-checking bench for pin_state_filter with STABLE_CYCLES=4, SETTLE_CYCLES=10.
module tb_pin_state_filter;

    localparam int unsigned N      = 3;
    localparam int unsigned STABLE = 4;
    localparam int unsigned SETTLE = 10;
    localparam int unsigned DC_W   = 2;
    localparam int          OFS    = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    ir_n = '0;
    logic            arm = 1'b0;
    logic [N-1:0]    pin_state;
    logic [N-1:0]    pin_down;
    logic [N-1:0]    pin_up;
    logic [DC_W-1:0] down_count;
    logic            all_down;
    logic            settled;
    logic            settle_pulse;

    int errors = 0;
    int checks = 0;

    pin_state_filter #(
        .N_PINS        (N),
        .STABLE_CYCLES (STABLE),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ir_n_i         (ir_n),
        .arm_i          (arm),
        .pin_state_o    (pin_state),
        .pin_down_o     (pin_down),
        .pin_up_o       (pin_up),
        .down_count_o   (down_count),
        .all_down_o     (all_down),
        .settled_o      (settled),
        .settle_pulse_o (settle_pulse)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a pin flips once the raw line, seen two edges late, has
    // disagreed with the held state for STABLE consecutive edges; the lane is settled
    // when SETTLE edges have passed since the last flip, arm or reset.
    logic [N-1:0] hist [0:4095];
    logic [N-1:0] m_state = '1;
    logic [N-1:0] m_down  = '0;
    logic [N-1:0] m_up    = '0;
    logic         m_settled = 1'b0;
    logic         m_pulse   = 1'b0;
    bit           model_valid = 1'b0;
    int           e = 0;
    int           last_event = 0;
    bit           mis;

    initial for (int i = 0; i < 4096; i++) hist[i] = '0;

    always @(posedge clk) begin
        e++;
        m_down = '0;
        m_up   = '0;
        if (rst) begin
            hist[e+OFS] = '0;
            m_state     = '1;
            last_event  = e;
        end else begin
            hist[e+OFS] = ir_n;
            for (int i = 0; i < int'(N); i++) begin
                mis = 1'b1;
                for (int j = 0; j < int'(STABLE); j++) begin
                    if (!hist[e+OFS-2-j][i] == m_state[i]) mis = 1'b0;
                end
                if (mis) begin
                    if (m_state[i]) m_down[i] = 1'b1;
                    else            m_up[i]   = 1'b1;
                    m_state[i] = ~m_state[i];
                end
            end
            if ((m_down | m_up) != '0 || arm) last_event = e;
        end
        m_settled   = (e - last_event) >= int'(SETTLE);
        m_pulse     = (e - last_event) == int'(SETTLE);
        model_valid = 1'b1;
    end

    // Per-cycle comparison of every output against the model
    always @(posedge clk) begin
        int zc;
        #1;
        if (model_valid) begin
            zc = 0;
            for (int i = 0; i < int'(N); i++) if (!m_state[i]) zc++;
            chk("pin_state",    32'(pin_state),    32'(m_state));
            chk("pin_down",     32'(pin_down),     32'(m_down));
            chk("pin_up",       32'(pin_up),       32'(m_up));
            chk("down_count",   32'(down_count),   32'(zc));
            chk("all_down",     32'(all_down),     32'(m_state == '0));
            chk("settled",      32'(settled),      32'(m_settled));
            chk("settle_pulse", 32'(settle_pulse), 32'(m_pulse));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic at_edge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Directed scenarios with hand-computed expectations
    initial begin
        // Reset with all pins standing
        cyc(3);
        rst = 1'b0;
        at_edge(1);
        chk("lit_reset_state", 32'(pin_state), 32'h7);
        chk("lit_reset_count", 32'(down_count), 32'h0);
        chk("lit_reset_settled", 32'(settled), 32'h0);
        at_edge(8);
        chk("lit_settle_early", 32'(settled), 32'h0);
        at_edge(1);
        chk("lit_settle_rise", 32'(settled), 32'h1);
        chk("lit_settle_pulse", 32'(settle_pulse), 32'h1);
        at_edge(1);
        chk("lit_settle_pulse_once", 32'(settle_pulse), 32'h0);

        // Clean fall of pin 1
        @(negedge clk);
        ir_n = 3'b010;
        at_edge(5);
        chk("lit_fall_not_yet", 32'(pin_state), 32'h7);
        at_edge(1);
        chk("lit_fall_pulse", 32'(pin_down), 32'h2);
        chk("lit_fall_state", 32'(pin_state), 32'h5);
        chk("lit_fall_count", 32'(down_count), 32'h1);
        chk("lit_fall_settled_drop", 32'(settled), 32'h0);
        at_edge(9);
        chk("lit_fall_settle_early", 32'(settled), 32'h0);
        at_edge(1);
        chk("lit_fall_settle_rise", 32'(settle_pulse), 32'h1);

        // Three-cycle glitch on pin 0
        @(negedge clk);
        ir_n = 3'b011;
        cyc(3);
        ir_n = 3'b010;
        at_edge(10);
        chk("lit_glitch_state", 32'(pin_state), 32'h5);
        chk("lit_glitch_settled", 32'(settled), 32'h1);

        // Restore pin 1, then all pins fall together
        @(negedge clk);
        ir_n = 3'b000;
        cyc(12);
        ir_n = 3'b111;
        at_edge(6);
        chk("lit_all_pulse", 32'(pin_down), 32'h7);
        chk("lit_all_count", 32'(down_count), 32'h3);
        chk("lit_all_down", 32'(all_down), 32'h1);
        cyc(13);

        // Arm while settled
        arm = 1'b1;
        at_edge(1);
        chk("lit_arm_drop", 32'(settled), 32'h0);
        @(negedge clk);
        arm = 1'b0;
        at_edge(10);
        chk("lit_arm_resettle", 32'(settle_pulse), 32'h1);

        // Arm on the same edge as a flip
        @(negedge clk);
        ir_n = 3'b000;
        cyc(5);
        arm = 1'b1;
        at_edge(1);
        chk("lit_arm_flip_up", 32'(pin_up), 32'h7);
        @(negedge clk);
        arm = 1'b0;
        at_edge(9);
        chk("lit_arm_flip_early", 32'(settled), 32'h0);
        at_edge(1);
        chk("lit_arm_flip_settle", 32'(settle_pulse), 32'h1);

        // Reset while pin 2 is mid-count
        @(negedge clk);
        ir_n = 3'b100;
        at_edge(5);
        @(negedge clk);
        rst  = 1'b1;
        ir_n = 3'b000;
        cyc(2);
        rst = 1'b0;
        at_edge(1);
        chk("lit_rst_mid_state", 32'(pin_state), 32'h7);
        chk("lit_rst_mid_pulse", 32'(pin_down), 32'h0);
        cyc(15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pin_state_filter.md
# pin_state_filter

Conditions the raw infra-red pin sensors of the bowling lane into clean per-pin state for the scoring logic. It sits between the board IR inputs and the player/score controller: synchronises each channel, rejects glitches shorter than a stability window, emits per-pin edge pulses, and flags when the lane has stopped changing so the controller can close a roll.

## Interface
- N_PINS, 3, number of pin sensor channels
- STABLE_CYCLES, 1_000_000, cycles a synchronised sample must differ from current state before state flips (10 ms at 100 MHz); minimum 2
- SETTLE_CYCLES, 100_000_000, cycles without any filtered change before `settled` asserts (1 s); minimum 2
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- ir_n  in  N_PINS  raw sensor lines, asynchronous; 0 = beam reflected = pin up
- arm  in  1  one-cycle pulse from controller at start of a roll; restarts settle timing
- pin_state  out  N_PINS  filtered state, 1 = pin up
- pin_down  out  N_PINS  one-cycle pulse when bit of pin_state falls 1->0
- pin_up  out  N_PINS  one-cycle pulse when bit of pin_state rises 0->1
- down_count  out  $clog2(N_PINS+1)  number of zero bits in pin_state
- all_down  out  1  pin_state == 0
- settled  out  1  level: no filtered change and no arm for SETTLE_CYCLES cycles
- settle_pulse  out  1  one-cycle pulse on the cycle settled rises

## Operation
- Reset values: pin_state all ones, pin_down/pin_up 0, down_count 0, all_down 0, settled 0, settle_pulse 0, all counters and synchroniser flops cleared to the "pin up" level (sync = 0).
- Per channel: two-flop synchroniser on ir_n[i]; sample s = ~sync2 (1 = up).
- Per channel stability counter, width $clog2(STABLE_CYCLES): if s == pin_state[i], counter <= 0; else if counter == STABLE_CYCLES-1, pin_state[i] <= s, counter <= 0, assert pin_down[i] or pin_up[i] that edge; else counter <= counter+1.
- A glitch that returns to the held state before the count completes clears the counter; no partial credit carries over.
- Settle counter, width $clog2(SETTLE_CYCLES+1): cleared to 0 on any edge where any channel flips or arm is high (both at once: single clear); otherwise increments, saturating at SETTLE_CYCLES.
- settled = (settle counter == SETTLE_CYCLES), registered. settle_pulse high only on the edge the counter reaches SETTLE_CYCLES.
- down_count and all_down are registered from the next-state value of pin_state, so they change on the same edge as pin_state.
- Multiple channels may flip on the same edge; each emits its own pulse, down_count reflects all.
- rst asserted mid-count: all state returns to reset values immediately; no pulses generated by reset itself.

## Timing
- ir_n change captured into sync1 at edge k -> pin_state and edge pulse update at edge k+1+STABLE_CYCLES, provided ir_n held stable.
- Last filtered flip (or arm) at edge m -> settled and settle_pulse at edge m+SETTLE_CYCLES.
- settled drops on the edge of any flip or arm (same edge the counter clears).
- No handshake; all outputs are registered, pulses exactly one cycle wide.

## Structure
- Shared package: N_PINS, PIN_UP = 1'b1 / PIN_DOWN = 1'b0 encoding, default STABLE_CYCLES and SETTLE_CYCLES constants for 100 MHz; reused by score/sound/VGA blocks.
- One sub-module natural: pin_channel_filter (synchroniser + stability counter + edge pulses for one channel), instantiated N_PINS times by generate loop; settle timer and count logic in the top of this block.

## Test plan
Bench uses STABLE_CYCLES=4, SETTLE_CYCLES=10.
- Reset: rst high then low with ir_n=3'b000 -> pin_state=3'b111, down_count=0, settled 0 until 10 edges later, then settle_pulse once.
- Clean fall: ir_n[1] 0->1 held -> pin_down[1] single pulse and pin_state=3'b101 exactly 5 edges after sync1 capture; down_count=1; settled drops that edge, rises 10 edges later.
- Glitch: ir_n[0] high for 3 cycles then low -> no pulse, pin_state unchanged, settle counter not cleared.
- Simultaneous: ir_n all 0->1 same cycle -> three pin_down bits pulse same edge, down_count=3, all_down=1.
- Arm while settled: arm pulse -> settled 0 next edge, settle_pulse again after 10 edges; arm coinciding with a flip clears once.
- Reset mid-count: rst during channel 2 count at 3 -> no pulse, pin_state=3'b111 after release.
